// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad codes and the BCD converter state type.
package calc_pkg;

  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
  localparam logic [4:0] KEY_BACKSPACE = 5'd10;
  localparam logic [4:0] KEY_SIGN      = 5'd11;

  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_e;

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first,
// restartable by start and cancellable by abort.
module bcd_to_bin_seq
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int VALUE_W    = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4*MAX_DIGITS-1:0] digits,
  output logic [VALUE_W-1:0]      value,
  output logic                    value_valid
);

  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MAX_DIGITS - 1);

  conv_state_e          state_q, state_d;
  logic [VALUE_W-1:0]   acc_q, acc_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [3:0]           cur_dig;
  logic [VALUE_W-1:0]   step;

  function automatic logic [VALUE_W-1:0] mul10(input logic [VALUE_W-1:0] a);
    return (a << 3) + (a << 1);
  endfunction

  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_dig = digits[i*4 +: 4];
    end
    step = mul10(acc_q) + VALUE_W'(cur_dig);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    value_d = value_q;
    valid_d = valid_q;
    if (abort) begin
      state_d = CONV_IDLE;
      acc_d   = '0;
      idx_d   = IDX_TOP;
      value_d = '0;
      valid_d = 1'b1;
    end else if (start) begin
      // A new accept always restarts from the MSD, even mid-conversion.
      state_d = CONV_RUN;
      acc_d   = '0;
      idx_d   = IDX_TOP;
      valid_d = 1'b0;
    end else if (state_q == CONV_RUN) begin
      if (idx_q == '0) begin
        value_d = step;
        valid_d = 1'b1;
        state_d = CONV_IDLE;
      end else begin
        acc_d = step;
        idx_d = idx_q - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      acc_q   <= '0;
      idx_q   <= IDX_TOP;
      value_q <= '0;
      valid_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;

endmodule

// File: rtl/operand_entry_reg.sv
// Multi-digit BCD operand entry: press edge detect, digit shifter with
// backspace/sign handling, and a sequential conversion to binary magnitude.
module operand_entry_reg
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int VALUE_W    = 10,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               lock,
  input  logic               press,
  input  logic [4:0]         key,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic               negative,
  output logic [CNT_W-1:0]   digit_count,
  output logic               loaded,
  output logic               full,
  output logic               reject
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic                    press_q;
  logic [4*MAX_DIGITS-1:0] dig_q, dig_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic                    reject_q, reject_d;
  logic                    accept;
  logic                    conv_start;

  // press_q tracks press unconditionally so a key held across lock/clear never fires.
  assign accept = press & ~press_q & ~lock & ~clear;

  always_comb begin
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    reject_d   = 1'b0;
    conv_start = 1'b0;
    if (clear) begin
      dig_d = '0;
      cnt_d = '0;
      neg_d = 1'b0;
    end else if (accept) begin
      if (key <= KEY_DIGIT_MAX) begin
        if (cnt_q == CNT_MAX) begin
          reject_d = 1'b1;
        end else begin
          conv_start = 1'b1;
          if (cnt_q == CNT_W'(1) && dig_q[3:0] == 4'd0) begin
            dig_d[3:0] = key[3:0];
          end else begin
            for (int i = MAX_DIGITS - 1; i > 0; i--) dig_d[i*4 +: 4] = dig_q[(i-1)*4 +: 4];
            dig_d[3:0] = key[3:0];
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
      end else if (key == KEY_BACKSPACE) begin
        if (cnt_q == '0) begin
          reject_d = 1'b1;
        end else begin
          conv_start = 1'b1;
          for (int i = 0; i < MAX_DIGITS - 1; i++) dig_d[i*4 +: 4] = dig_q[(i+1)*4 +: 4];
          dig_d[4*MAX_DIGITS-1 -: 4] = 4'd0;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) neg_d = 1'b0;
        end
      end else if (key == KEY_SIGN) begin
        if (cnt_q == '0) begin
          reject_d = 1'b1;
        end else begin
          conv_start = 1'b1;
          neg_d      = ~neg_q;
        end
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_q  <= 1'b0;
      dig_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      press_q  <= press;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      reject_q <= reject_d;
    end
  end

  bcd_to_bin_seq #(
    .MAX_DIGITS(MAX_DIGITS),
    .VALUE_W   (VALUE_W)
  ) u_conv (
    .clock      (clock),
    .reset      (reset),
    .start      (conv_start),
    .abort      (clear),
    .digits     (dig_q),
    .value      (value),
    .value_valid(value_valid)
  );

  assign negative    = neg_q;
  assign digit_count = cnt_q;
  assign loaded      = (cnt_q != '0);
  assign full        = (cnt_q == CNT_MAX);
  assign reject      = reject_q;

endmodule

// File: tb/tb_operand_entry_reg.sv
// Randomized bench for operand_entry_reg against an integer-arithmetic operand model.
module tb_operand_entry_reg;

  localparam int MD = 3;
  localparam int VW = 10;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset, clear, lock, press;
  logic [4:0]    key;
  logic [VW-1:0] value;
  logic          value_valid, negative, loaded, full, reject;
  logic [CW-1:0] digit_count;

  operand_entry_reg #(.MAX_DIGITS(MD), .VALUE_W(VW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .clear(clear), .lock(lock), .press(press), .key(key),
    .value(value), .value_valid(value_valid), .negative(negative),
    .digit_count(digit_count), .loaded(loaded), .full(full), .reject(reject)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Operand model: the entered number as an integer plus digit count and sign.
  int m_num, m_n;
  bit m_neg, m_start, m_rej;
  logic [19:0] obs, exp_v;
  logic [15:0] st, st_exp;

  task automatic model_reset();
    m_num = 0; m_n = 0; m_neg = 0;
  endtask

  task automatic model_apply(input int k);
    m_rej = 0; m_start = 0;
    if (k <= 9) begin
      if (m_n == MD) m_rej = 1;
      else begin
        m_start = 1;
        if (m_n == 1 && m_num == 0) m_num = k;
        else begin m_num = m_num * 10 + k; m_n++; end
      end
    end else if (k == 10) begin
      if (m_n == 0) m_rej = 1;
      else begin
        m_start = 1; m_num = m_num / 10; m_n--;
        if (m_n == 0) m_neg = 0;
      end
    end else if (k == 11) begin
      if (m_n == 0) m_rej = 1;
      else begin m_start = 1; m_neg = !m_neg; end
    end else m_rej = 1;
  endtask

  function automatic logic [19:0] expect_vec();
    return {m_rej, 1'b0, CW'(m_n), m_neg, (m_n != 0), (m_n == MD),
            !m_start, !m_start, 1'b1, VW'(m_num)};
  endfunction

  function automatic logic [15:0] state_vec();
    return {reject, digit_count, negative, loaded, full, value_valid, VW'(0) | value};
  endfunction

  function automatic logic [15:0] model_state();
    return {1'b0, CW'(m_n), m_neg, (m_n != 0), (m_n == MD), 1'b1, VW'(m_num)};
  endfunction

  // One-cycle press; samples flags after the accept edge and the value after the full latency.
  task automatic press_key(input int k);
    model_apply(k);
    @(negedge clock); key = 5'(k); press = 1'b1;
    @(negedge clock); press = 1'b0;
    obs[19] = reject; obs[17:16] = digit_count; obs[15] = negative;
    obs[14] = loaded; obs[13] = full; obs[12] = value_valid;
    @(negedge clock); obs[18] = reject;
    @(negedge clock); obs[11] = value_valid;
    @(negedge clock); obs[10] = value_valid; obs[9:0] = value;
    exp_v = expect_vec();
  endtask

  task automatic pulse_clear();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; lock = 1'b0; press = 1'b0; key = 5'd0;
    repeat (2) @(negedge clock);
    model_reset();
    st = state_vec(); st_exp = model_state();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL reset_state: got %h expected %h", st, st_exp);
    end
    reset = 1'b0;
  endtask

  task automatic test_entry();
    int ks[3] = '{1, 2, 3};
    foreach (ks[i]) begin
      press_key(ks[i]);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL entry key=%0d: got %h expected %h", ks[i], obs, exp_v);
      end
    end
  endtask

  task automatic test_reject();
    int ks[2] = '{4, 15};
    foreach (ks[i]) begin
      press_key(ks[i]);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL reject key=%0d: got %h expected %h", ks[i], obs, exp_v);
      end
    end
  endtask

  task automatic test_backspace();
    for (int i = 0; i < 4; i++) begin
      press_key(10);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL backspace #%0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_leading_zero_hold();
    int ks[3] = '{0, 0, 7};
    foreach (ks[i]) begin
      press_key(ks[i]);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL leading_zero key=%0d: got %h expected %h", ks[i], obs, exp_v);
      end
    end
    model_apply(5);
    @(negedge clock); key = 5'd5; press = 1'b1;
    repeat (10) @(negedge clock);
    press = 1'b0;
    repeat (4) @(negedge clock);
    st = state_vec(); st_exp = model_state();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL held_key: got %h expected %h", st, st_exp);
    end
  endtask

  task automatic test_sign_clear();
    int ks[3] = '{11, 5, 11};
    pulse_clear();
    st = state_vec(); st_exp = model_state();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL clear_state: got %h expected %h", st, st_exp);
    end
    foreach (ks[i]) begin
      press_key(ks[i]);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL sign key=%0d: got %h expected %h", ks[i], obs, exp_v);
      end
    end
    @(negedge clock); key = 5'd9; press = 1'b1; clear = 1'b1;
    @(negedge clock); clear = 1'b0; press = 1'b0;
    model_reset();
    st = state_vec(); st_exp = model_state();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL clear_with_press: got %h expected %h", st, st_exp);
    end
    repeat (4) @(negedge clock);
    st = state_vec();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL clear_press_dropped: got %h expected %h", st, st_exp);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      int a, b;
      a = $urandom_range(1, 9);
      b = $urandom_range(0, 9);
      pulse_clear();
      model_apply(a);
      @(negedge clock); key = 5'(a); press = 1'b1;
      @(negedge clock); press = 1'b0;
      press_key(b);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL back_to_back %0d,%0d: got %h expected %h", a, b, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_lock();
    pulse_clear();
    @(negedge clock); key = 5'd4; press = 1'b1;
    @(negedge clock); press = 1'b0;
    #1 reset = 1'b1;
    #1;
    model_reset();
    st = state_vec(); st_exp = model_state();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL async_reset: got %h expected %h", st, st_exp);
    end
    @(negedge clock); reset = 1'b0;
    repeat (4) @(negedge clock);
    st = state_vec();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL reset_no_pending: got %h expected %h", st, st_exp);
    end
    @(negedge clock); lock = 1'b1; key = 5'd6; press = 1'b1;
    @(negedge clock);
    st = state_vec();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL lock_press: got %h expected %h", st, st_exp);
    end
    @(negedge clock); lock = 1'b0;
    repeat (4) @(negedge clock);
    st = state_vec();
    vectors++;
    if (st !== st_exp) begin
      miscompares++; $display("FAIL lock_release_held: got %h expected %h", st, st_exp);
    end
    press = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      int k;
      if ($urandom_range(0, 15) == 0) begin
        pulse_clear();
        st = state_vec(); st_exp = model_state();
        vectors++;
        if (st !== st_exp) begin
          miscompares++; $display("FAIL random_clear #%0d: got %h expected %h", i, st, st_exp);
        end
      end else begin
        k = $urandom_range(0, 13);
        press_key(k);
        vectors++;
        if (obs !== exp_v) begin
          miscompares++; $display("FAIL random #%0d key=%0d: got %h expected %h", i, k, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_reject();
    test_backspace();
    test_leading_zero_hold();
    test_sign_clear();
    test_back_to_back();
    test_reset_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
